// File: rtl/seq_detect_prog.sv
// Programmable Moore serial-pattern detector: runtime-loadable pattern and
// overlap mode, sample-enable qualifier and a saturating match counter.
module seq_detect_prog #(
   parameter int unsigned        PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PAT_RST = 4'b1101,
   parameter logic               OVL_RST = 1'b1,
   parameter int unsigned        CNT_W   = 8
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               en,
   input  logic               seq,
   input  logic               cfg_load,
   input  logic [PAT_LEN-1:0] cfg_pattern,
   input  logic               cfg_overlap,
   output logic               det,
   output logic [CNT_W-1:0]   match_cnt
);

   localparam int unsigned        FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
   localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(PAT_LEN - 1);

   // The oldest history bit is shifted out before it is ever compared, so only
   // PAT_LEN-1 bits need to be kept.
   logic [PAT_LEN-2:0] hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [PAT_LEN-1:0] pat_q, pat_d;
   logic               ovl_q, ovl_d;
   logic               det_q, det_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [PAT_LEN-1:0] nh;
   logic               hit;

   always_comb begin
      nh     = {hist_q, seq};
      hit    = (fill_q >= FILL_LAST) && (nh == pat_q);
      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      ovl_d  = ovl_q;
      det_d  = 1'b0;
      cnt_d  = cnt_q;
      if (cfg_load) begin
         pat_d  = cfg_pattern;
         ovl_d  = cfg_overlap;
         hist_d = '0;
         fill_d = '0;
         cnt_d  = '0;
      end else if (en) begin
         hist_d = nh[PAT_LEN-2:0];
         det_d  = hit;
         if (hit && !ovl_q) begin
            fill_d = '0;
         end else if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FILL_W'(1);
         end
         // Counter saturates at all-ones instead of wrapping.
         if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= PAT_RST;
         ovl_q  <= OVL_RST;
         det_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         ovl_q  <= ovl_d;
         det_q  <= det_d;
         cnt_q  <= cnt_d;
      end
   end

   assign det       = det_q;
   assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus randomized traffic,
// checked against a queue-based reference model (8-bit and 2-bit counters).
module tb_seq_detect_prog;

   localparam int PL = 4;

   logic       clk = 1'b0;
   logic       arst;
   logic       en;
   logic       seq;
   logic       cfg_load;
   logic [3:0] cfg_pattern;
   logic       cfg_overlap;
   logic       det;
   logic       det2;
   logic [7:0] cnt;
   logic [1:0] cnt2;

   int total = 0;
   int bad   = 0;

   bit         mq[$];
   logic [3:0] m_pat;
   bit         m_ovl;
   int         m_cnt;
   bit         m_det;

   seq_detect_prog u_dut (
      .clk(clk), .arst(arst), .en(en), .seq(seq), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
      .det(det), .match_cnt(cnt)
   );

   seq_detect_prog #(.CNT_W(2)) u_dut2 (
      .clk(clk), .arst(arst), .en(en), .seq(seq), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
      .det(det2), .match_cnt(cnt2)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_pat = 4'b1101;
      m_ovl = 1'b1;
      m_cnt = 0;
      m_det = 1'b0;
   endfunction

   // Hit = the last PL accepted bits since the last clear spell the pattern.
   function automatic void model_step();
      logic [3:0] w;
      bit hit;
      hit = 1'b0;
      w   = '0;
      if (cfg_load) begin
         m_pat = cfg_pattern;
         m_ovl = cfg_overlap;
         mq.delete();
         m_cnt = 0;
         m_det = 1'b0;
      end else if (en) begin
         mq.push_back(seq);
         if (mq.size() >= PL) begin
            for (int i = 0; i < PL; i++) w[PL-1-i] = mq[mq.size()-PL+i];
            hit = (w == m_pat);
         end
         m_det = hit;
         if (hit) m_cnt++;
         if (hit && !m_ovl) mq.delete();
         if (mq.size() > 64) void'(mq.pop_front());
      end else begin
         m_det = 1'b0;
      end
   endfunction

   task automatic check_all(string tag);
      chk({tag, ".det"},  {31'd0, det},  {31'd0, m_det});
      chk({tag, ".det2"}, {31'd0, det2}, {31'd0, m_det});
      chk({tag, ".cnt"},  {24'd0, cnt},  (m_cnt > 255) ? 255 : m_cnt);
      chk({tag, ".cnt2"}, {30'd0, cnt2}, (m_cnt > 3) ? 3 : m_cnt);
   endtask

   task automatic drive(string tag, bit e, bit s, bit ld, logic [3:0] p, bit o);
      en = e; seq = s; cfg_load = ld; cfg_pattern = p; cfg_overlap = o;
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
      @(negedge clk);
      cfg_load = 1'b0;
   endtask

   task automatic cyc(string tag, bit e, bit s);
      drive(tag, e, s, 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic load(string tag, logic [3:0] p, bit o);
      drive(tag, 1'b0, 1'b0, 1'b1, p, o);
   endtask

   task automatic stream(string tag, logic [15:0] bits, int n);
      for (int i = n - 1; i >= 0; i--) cyc(tag, 1'b1, bits[i]);
   endtask

   initial begin
      arst = 1'b1; en = 1'b0; seq = 1'b0; cfg_load = 1'b0;
      cfg_pattern = 4'b0000; cfg_overlap = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.det", {31'd0, det}, 0);
      chk("rst.cnt", {24'd0, cnt}, 0);
      arst = 1'b0;

      stream("ovl1101", 16'b1101101, 7);
      chk("ovl1101.final", {24'd0, cnt}, 2);

      load("ld_novl", 4'b1101, 1'b0);
      stream("novl1101", 16'b1101101, 7);
      chk("novl1101.final", {24'd0, cnt}, 1);

      load("ld_1111o", 4'b1111, 1'b1);
      stream("ovl1111", 16'b111111, 6);
      chk("ovl1111.final", {24'd0, cnt}, 3);
      load("ld_1111n", 4'b1111, 1'b0);
      stream("novl1111", 16'b111111, 6);
      chk("novl1111.final", {24'd0, cnt}, 1);

      load("ld_gap", 4'b1101, 1'b1);
      cyc("gap", 1'b1, 1'b1);
      cyc("gap", 1'b1, 1'b1);
      cyc("gap_off", 1'b0, 1'b0);
      cyc("gap_off", 1'b0, 1'b1);
      cyc("gap", 1'b1, 1'b0);
      cyc("gap", 1'b1, 1'b1);
      chk("gap.final", {24'd0, cnt}, 1);

      load("ld_sat2", 4'b1101, 1'b1);
      repeat (5) stream("sat2", 16'b1101, 4);
      chk("sat2.cnt", {24'd0, cnt}, 5);
      chk("sat2.cnt2", {30'd0, cnt2}, 3);

      load("ld_arst", 4'b1101, 1'b1);
      stream("arst_pre", 16'b1101, 4);
      chk("arst_pre.det", {31'd0, det}, 1);
      arst = 1'b1;
      #1;
      model_reset();
      chk("arst_async.det", {31'd0, det}, 0);
      check_all("arst_async");
      #1 arst = 1'b0;
      stream("arst_mid", 16'b110, 3);
      arst = 1'b1;
      #2 arst = 1'b0;
      model_reset();
      cyc("arst_post", 1'b1, 1'b1);
      chk("arst_post.det", {31'd0, det}, 0);
      chk("arst_post.cnt", {24'd0, cnt}, 0);

      load("ld_live", 4'b1101, 1'b1);
      stream("live", 16'b110110, 6);
      drive("live_ld", 1'b1, 1'b1, 1'b1, 4'b1101, 1'b1);
      chk("live_ld.cnt", {24'd0, cnt}, 0);
      cyc("live_post", 1'b1, 1'b1);
      chk("live_post.det", {31'd0, det}, 0);

      load("ld_sat8", 4'b1111, 1'b1);
      repeat (262) cyc("sat8", 1'b1, 1'b1);
      chk("sat8.final", {24'd0, cnt}, 255);

      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(39) == 0) begin
            logic [3:0] p;
            p = 4'($urandom);
            if ($urandom_range(3) == 0) p = ($urandom_range(1) == 0) ? 4'b1111 : 4'b0000;
            drive("rnd_ld", 1'($urandom), 1'($urandom), 1'b1, p, 1'($urandom));
         end else begin
            cyc("rnd", $urandom_range(3) != 0, 1'($urandom));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
